anemo_freq_meter: RTL and testbench
===================================

// Module: anemo_freq_meter
// PURPOSE
//  Measures the anemometer pulse frequency in Hz and reports it as an 8-bit wind-speed value.
//  Sits downstream of the 8-bit control PIO in the anemometer SOPC and consumes its out_port as ctrl.
//  Counts rising edges of the raw in_freq signal over a fixed gate window.
//  Supports continuous and single-shot (start/stop handshake) modes.
// PARAMETERS
//  GATE_CYCLES  50_000_000  gate length in clk cycles (1 s at 50 MHz); must be >= 2
//  DATA_W       8           width of data_anemo; the count saturates at 2**DATA_W-1
// PORTS
//  clk         in   1       system clock; single clock domain
//  reset_n     in   1       synchronous, active-low reset, sampled on posedge clk
//  ctrl        in   8       from control PIO: [0]=continu, [1]=start_stop, [7:2]=ignored
//  in_freq     in   1       raw anemometer pulse, asynchronous to clk
//  data_anemo  out  DATA_W  last completed measurement, in edges per gate
//  data_valid  out  1       measurement-available flag (mode dependent, see below)
// BEHAVIOUR
//  Reset (reset_n=0 at posedge clk):
//   - data_anemo=0, data_valid=0, state=IDLE
//   - gate_cnt=0, edge_cnt=0, synchroniser flops=0
//  Synchroniser: in_freq -> s0 -> s1 -> s2; rise = s1 & ~s2.
//   - rise asserts 2 cycles after in_freq goes high and is 1 cycle wide.
//  edge_cnt: DATA_W bits; increments on rise while state=GATE; saturates at all-ones, no wrap.
//  gate_cnt: counts 0..GATE_CYCLES-1 while in GATE.
//  Gate-end cycle (gate_cnt==GATE_CYCLES-1): data_anemo <= sat(edge_cnt + rise).
//   - A rise in the last gate cycle counts in the closing window.
//   - edge_cnt and gate_cnt clear to 0 in the same cycle.
//  States:
//   IDLE: edge_cnt/gate_cnt held at 0.
//    - -> GATE when continu=1, or when start_stop=1 (level, sampled each cycle).
//   GATE: counting. At gate end:
//    - continu=1 -> stay in GATE; the next window starts in the following cycle with no dead cycle.
//      data_valid pulses high for exactly 1 cycle.
//    - continu=0 -> DONE; data_valid <= 1.
//   DONE: data_valid held 1; data_anemo stable.
//    - start_stop=0 -> IDLE; data_valid <= 0 on the same clock edge.
//    - continu=1 -> GATE; data_valid <= 0.
//  Mode/ctrl changes mid-gate:
//   - The gate always runs to completion; continu is sampled only at gate end.
//   - start_stop=0 during GATE does not abort the gate.
//   - If start_stop=0 at gate end in single mode, go to DONE, then to IDLE next cycle.
//     data_valid is high for 1 cycle.
//  data_anemo changes only at a gate end or on reset; it is never cleared by IDLE.
//  Reset mid-gate: partial count discarded; data_anemo=0; no data_valid.
//  ctrl[7:2] has no effect.
// TESTING (GATE_CYCLES=100 unless stated)
//  1. Continuous: ctrl=8'h01, in_freq period 10 clk (50% duty) ->
//     data_anemo=10 each window; data_valid 1-cycle pulse every 100 cycles.
//  2. Single-shot: ctrl=8'h02, 7 pulses inside the window ->
//     data_valid rises after 100 gate cycles and stays 1, data_anemo=7;
//     then ctrl=8'h00 -> data_valid=0 one clock later, data_anemo still 7.
//  3. Saturation (GATE_CYCLES=1000, DATA_W=8): in_freq period 2 clk ->
//     500 edges -> data_anemo=255, no wrap.
//  4. Boundary: one rise landing on gate_cnt=99 -> counted in that window (data_anemo=1);
//     rise at the next window's gate_cnt=0 -> counted in the next window.
//  5. Reset mid-gate: ctrl=8'h01, reset_n=0 at gate_cnt=50 with 5 edges counted ->
//     data_anemo=0, data_valid=0; the next full window reports the correct count.
//  6. Stuck input and ignored bits: in_freq constant 1, ctrl=8'hFD (continu=1) ->
//     data_anemo=0 every window; bits [7:2] change nothing.

Source files
------------

// File: rtl/anemo_freq_meter.sv
// anemo_freq_meter: counts anemometer pulse rising edges per gate window and reports the count.
//   clk        : system clock
//   reset_n    : synchronous active-low reset
//   ctrl       : [0]=continu (free-running windows), [1]=start_stop (single-shot request), [7:2] unused
//   in_freq    : raw anemometer pulse, asynchronous to clk
//   data_anemo : last completed measurement (edges per gate, saturating)
//   data_valid : 1-cycle pulse per window in continuous mode, held level in single-shot DONE
module anemo_freq_meter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        ctrl,
  input  logic              in_freq,
  output logic [DATA_W-1:0] data_anemo,
  output logic              data_valid
);
  localparam int GW = $clog2(GATE_CYCLES);
  typedef enum logic [1:0] {IDLE, GATE, DONE} state_e;
  state_e            state_q, state_d;
  logic              s0_q, s1_q, s2_q;
  logic [GW-1:0]     gate_cnt_q, gate_cnt_d;
  logic [DATA_W-1:0] edge_cnt_q, edge_cnt_d, data_q, data_d, edge_sum;
  logic              valid_q, valid_d;
  logic              continu, start_stop, rise, gate_end;
  logic              unused_ctrl;
  assign continu     = ctrl[0];
  assign start_stop  = ctrl[1];
  assign unused_ctrl = ^ctrl[7:2];
  assign rise        = s1_q & ~s2_q;
  assign gate_end    = (state_q == GATE) && (gate_cnt_q == GW'(GATE_CYCLES - 1));
  // includes the rise of the current cycle so a last-cycle edge lands in the closing window
  assign edge_sum    = (&edge_cnt_q) ? edge_cnt_q : edge_cnt_q + {{(DATA_W-1){1'b0}}, rise};
  assign data_anemo  = data_q;
  assign data_valid  = valid_q;
  always_comb begin
    state_d    = state_q;
    gate_cnt_d = '0;
    edge_cnt_d = '0;
    data_d     = data_q;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: state_d = (continu | start_stop) ? GATE : IDLE;
      GATE: begin
        gate_cnt_d = gate_end ? '0 : gate_cnt_q + GW'(1);
        edge_cnt_d = gate_end ? '0 : edge_sum;
        data_d     = gate_end ? edge_sum : data_q;
        valid_d    = gate_end;
        // continu is only looked at here, so a gate always runs to completion
        state_d    = (gate_end && !continu) ? DONE : GATE;
      end
      DONE: begin
        state_d = !start_stop ? IDLE : (continu ? GATE : DONE);
        valid_d = start_stop && !continu;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      s0_q       <= in_freq;
      s1_q       <= s0_q;
      s2_q       <= s1_q;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end
endmodule

// File: tb/tb_anemo_freq_meter.sv
// tb_anemo_freq_meter: directed and random checks of anemo_freq_meter against a window-count model.
module tb_anemo_freq_meter;
  localparam int G    = 100;
  localparam int MAXE = 16384;
  localparam int M_IDLE = 0, M_GATE = 1, M_DONE = 2;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] ctrl = 8'h00;
  logic       in_lvl = 1'b0;
  logic       gen_en = 1'b0;
  logic       gen_bit = 1'b0;
  int         gen_per = 10;
  logic       in_freq;
  logic [7:0] data_anemo;
  logic       data_valid;
  logic       reset_s_n = 1'b0;
  logic [7:0] ctrl_s = 8'h00;
  logic       in_s = 1'b0;
  logic [7:0] data_s;
  logic       valid_s;
  int         n = 0;
  int         errors = 0;
  int         checks = 0;
  bit         samp [MAXE];
  int         ms = M_IDLE;
  int         wstart = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0;
  assign in_freq = gen_en ? gen_bit : in_lvl;
  anemo_freq_meter #(.GATE_CYCLES(G), .DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .ctrl(ctrl), .in_freq(in_freq),
    .data_anemo(data_anemo), .data_valid(data_valid)
  );
  anemo_freq_meter #(.GATE_CYCLES(1000), .DATA_W(8)) dut_sat (
    .clk(clk), .reset_n(reset_s_n), .ctrl(ctrl_s), .in_freq(in_s),
    .data_anemo(data_s), .data_valid(valid_s)
  );
  always #5 clk = ~clk;
  always @(negedge clk) gen_bit <= (n % gen_per) < (gen_per / 2);
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, n, act, exp);
    end
  endtask
  // rising edges seen by the meter at clock edges a..b: input sampled high two edges back, low three back
  function automatic int rises(input int a, input int b);
    int c = 0;
    for (int e = a; e <= b; e++) if (e >= 3 && samp[e-2] && !samp[e-3]) c++;
    return c;
  endfunction
  initial begin : model
    forever begin
      @(posedge clk);
      n++;
      if (!reset_n) begin
        samp[n] = 1'b0;
        ms = M_IDLE;
        m_data = 8'h00;
        m_valid = 1'b0;
      end else begin
        samp[n] = in_freq;
        if (ms == M_IDLE) begin
          m_valid = 1'b0;
          if (ctrl[0] || ctrl[1]) begin ms = M_GATE; wstart = n; end
        end else if (ms == M_GATE) begin
          m_valid = 1'b0;
          if (n == wstart + G) begin
            m_data = 8'(rises(wstart + 1, n) > 255 ? 255 : rises(wstart + 1, n));
            m_valid = 1'b1;
            if (ctrl[0]) wstart = n;
            else ms = M_DONE;
          end
        end else begin
          if (!ctrl[1]) begin ms = M_IDLE; m_valid = 1'b0; end
          else if (ctrl[0]) begin ms = M_GATE; wstart = n; m_valid = 1'b0; end
        end
      end
    end
  end
  initial begin : compare
    wait (n >= 1);
    forever begin
      @(negedge clk);
      chk("cyc_data_anemo", int'(data_anemo), int'(m_data));
      chk("cyc_data_valid", int'(data_valid), int'(m_valid));
    end
  end
  task automatic at_neg(input int k);
    while (n < k) @(negedge clk);
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    at_neg(n + 3);
    reset_n = 1'b1;
  endtask
  initial begin : main
    int w, r, s0;
    at_neg(3);
    chk("reset_data", int'(data_anemo), 0);
    chk("reset_valid", int'(data_valid), 0);
    reset_n = 1'b1;
    reset_s_n = 1'b1;
    ctrl_s = 8'h01;
    s0 = n + 1;
    while (n < s0 + 2000) begin
      @(negedge clk);
      in_s = ~in_s;
      if (n == s0 + 999) begin
        chk("sat_before_data", int'(data_s), 0);
        chk("sat_before_valid", int'(valid_s), 0);
      end
      if (n == s0 + 1000) begin
        chk("sat_data", int'(data_s), 255);
        chk("sat_valid", int'(valid_s), 1);
      end
      if (n == s0 + 1001) chk("sat_pulse", int'(valid_s), 0);
      if (n == s0 + 2000) chk("sat_data2", int'(data_s), 255);
    end
    gen_per = 10;
    gen_en = 1'b1;
    at_neg(n + 20);
    ctrl = 8'h01;
    w = n + 1;
    for (int i = 1; i <= 3; i++) begin
      at_neg(w + 100 * i);
      chk("cont_data", int'(data_anemo), 10);
      chk("cont_valid", int'(data_valid), 1);
      at_neg(w + 100 * i + 1);
      chk("cont_pulse", int'(data_valid), 0);
    end
    do_reset();
    gen_en = 1'b0;
    in_lvl = 1'b0;
    ctrl = 8'h02;
    w = n + 1;
    for (int i = 0; i < 7; i++) begin
      at_neg(w + 1 + 10 * i);
      in_lvl = 1'b1;
      at_neg(w + 6 + 10 * i);
      in_lvl = 1'b0;
    end
    at_neg(w + 99);
    chk("single_early_valid", int'(data_valid), 0);
    at_neg(w + 100);
    chk("single_data", int'(data_anemo), 7);
    chk("single_valid", int'(data_valid), 1);
    at_neg(w + 104);
    chk("single_held", int'(data_valid), 1);
    ctrl = 8'h00;
    at_neg(w + 105);
    chk("single_release_valid", int'(data_valid), 0);
    chk("single_release_data", int'(data_anemo), 7);
    at_neg(n + 3);
    ctrl = 8'h01;
    w = n + 1;
    at_neg(w + 97);
    in_lvl = 1'b1;
    at_neg(w + 98);
    in_lvl = 1'b0;
    at_neg(w + 100);
    chk("edge_last_cycle", int'(data_anemo), 1);
    at_neg(w + 198);
    in_lvl = 1'b1;
    at_neg(w + 200);
    chk("edge_quiet_window", int'(data_anemo), 0);
    at_neg(w + 300);
    chk("edge_first_cycle", int'(data_anemo), 1);
    in_lvl = 1'b0;
    gen_en = 1'b1;
    at_neg(w + 448);
    while (n % 10 < 5) @(negedge clk);
    reset_n = 1'b0;
    r = n + 1;
    at_neg(r);
    chk("midreset_data", int'(data_anemo), 0);
    chk("midreset_valid", int'(data_valid), 0);
    reset_n = 1'b1;
    w = r + 1;
    at_neg(w + 100);
    chk("after_reset_data", int'(data_anemo), 10);
    chk("after_reset_valid", int'(data_valid), 1);
    at_neg(w + 150);
    in_lvl = 1'b1;
    gen_en = 1'b0;
    ctrl = 8'hFD;
    at_neg(w + 250);
    ctrl = 8'hA9;
    at_neg(w + 300);
    chk("stuck_data", int'(data_anemo), 0);
    chk("stuck_valid", int'(data_valid), 1);
    ctrl = 8'h55;
    at_neg(w + 400);
    chk("stuck_data2", int'(data_anemo), 0);
    do_reset();
    in_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset_n = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 119) == 0) ctrl = 8'($urandom);
      if ($urandom_range(0, 2) == 0) in_lvl = ~in_lvl;
    end
    at_neg(n + 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
